// File: rtl/tile_frame_renderer.sv
// Tile-mapped raster renderer for an LT24-class panel: one pixel per handshake,
// tile-map lookup, texture fetch and colour-keyed sprite overlay.
module tile_frame_renderer #(
  parameter int unsigned SCREEN_W     = 240,
  parameter int unsigned SCREEN_H     = 320,
  parameter int unsigned TILE_LOG2    = 3,
  parameter int unsigned MAP_W        = 30,
  parameter int unsigned MAP_H        = 40,
  parameter int unsigned TILE_BITS    = 2,
  parameter int unsigned ROM_LAT      = 1,
  parameter logic [15:0] TRANSPARENT  = 16'h07E0,
  parameter logic [15:0] BLANK_COLOUR = 16'h0000,
  localparam int unsigned XW  = $clog2(SCREEN_W),
  localparam int unsigned YW  = $clog2(SCREEN_H),
  localparam int unsigned SXW = $clog2(MAP_W),
  localparam int unsigned SYW = $clog2(MAP_H),
  localparam int unsigned MAW = $clog2(MAP_W * MAP_H),
  localparam int unsigned TAW = TILE_BITS + 2 * TILE_LOG2,
  localparam int unsigned SAW = 2 * TILE_LOG2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 blank,
  input  logic                 sprite_en,
  input  logic [SXW-1:0]       sprite_x,
  input  logic [SYW-1:0]       sprite_y,
  output logic [MAW-1:0]       map_addr,
  input  logic [TILE_BITS-1:0] map_code,
  output logic [TAW-1:0]       tex_addr,
  input  logic [15:0]          tex_data,
  output logic [SAW-1:0]       spr_addr,
  input  logic [15:0]          spr_data,
  output logic [XW-1:0]        xAddr,
  output logic [YW-1:0]        yAddr,
  output logic [15:0]          pixelData,
  output logic                 pixelWrite,
  input  logic                 pixelReady,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int unsigned CNTW = $clog2(ROM_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAP, S_TEX, S_OUT} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNTW-1:0]      r_cnt;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic [XW-1:0]        w_nx;
  logic [YW-1:0]        w_ny;
  logic                 r_blank;
  logic                 r_spr_en;
  logic [SXW-1:0]       r_spr_x;
  logic [SYW-1:0]       r_spr_y;
  logic                 r_offmap;
  logic [MAW-1:0]       r_map_addr;
  logic [TAW-1:0]       r_tex_addr;
  logic [SAW-1:0]       r_spr_addr;
  logic [15:0]          r_pixel;
  logic                 r_frame_done;

  logic                 w_hold_done;
  logic                 w_xfer;
  logic                 w_last_x;
  logic                 w_last_y;
  logic                 w_frame_end;
  logic                 w_latch;
  logic                 w_enter_map;
  logic [XW-TILE_LOG2-1:0] w_col;
  logic [YW-TILE_LOG2-1:0] w_row;
  logic                 w_offmap;
  logic [MAW-1:0]       w_map_addr;
  logic                 w_spr_hit;
  logic [15:0]          w_pixel;

  assign w_hold_done = (r_cnt == CNTW'(ROM_LAT));
  assign w_xfer      = (r_state == S_OUT) && pixelReady;
  assign w_last_x    = (r_x == XW'(SCREEN_W - 1));
  assign w_last_y    = (r_y == YW'(SCREEN_H - 1));
  assign w_frame_end = w_xfer && w_last_x && w_last_y;
  assign w_latch     = enable && ((r_state == S_IDLE) || w_frame_end);

  // Raster position that will hold after this edge; the map address is
  // computed from it so it is already registered on MAP entry.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (w_xfer) begin
      if (w_last_x) begin
        w_nx = '0;
        w_ny = w_last_y ? '0 : r_y + YW'(1);
      end else begin
        w_nx = r_x + XW'(1);
      end
    end
  end

  always_comb begin
    w_col      = w_nx[XW-1:TILE_LOG2];
    w_row      = w_ny[YW-1:TILE_LOG2];
    w_offmap   = (32'(w_col) >= MAP_W) || (32'(w_row) >= MAP_H);
    w_map_addr = '0;
    if (!w_offmap) begin
      w_map_addr = MAW'(w_col) + MAW'(MAP_W) * MAW'(w_row);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (enable) w_state_next = S_MAP;
      S_MAP:  if (w_hold_done) w_state_next = S_TEX;
      S_TEX:  if (w_hold_done) w_state_next = S_OUT;
      S_OUT: begin
        if (w_xfer) begin
          if (w_frame_end && !enable) w_state_next = S_IDLE;
          else                        w_state_next = S_MAP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_enter_map = (w_state_next == S_MAP) && (r_state != S_MAP);

  always_comb begin
    w_spr_hit = r_spr_en
             && (32'(r_x[XW-1:TILE_LOG2]) == 32'(r_spr_x))
             && (32'(r_y[YW-1:TILE_LOG2]) == 32'(r_spr_y))
             && (spr_data != TRANSPARENT);
    w_pixel = tex_data;
    if (r_blank || r_offmap) w_pixel = BLANK_COLOUR;
    else if (w_spr_hit)      w_pixel = spr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset || (w_state_next != r_state)) begin
      r_cnt <= '0;
    end else if ((r_state == S_MAP) || (r_state == S_TEX)) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_blank      <= 1'b0;
      r_spr_en     <= 1'b0;
      r_spr_x      <= '0;
      r_spr_y      <= '0;
      r_offmap     <= 1'b0;
      r_map_addr   <= '0;
      r_tex_addr   <= '0;
      r_spr_addr   <= '0;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_x          <= w_nx;
      r_y          <= w_ny;
      r_frame_done <= w_frame_end;
      if (w_latch) begin
        r_blank  <= blank;
        r_spr_en <= sprite_en;
        r_spr_x  <= sprite_x;
        r_spr_y  <= sprite_y;
      end
      if (w_enter_map) begin
        r_map_addr <= w_map_addr;
        r_offmap   <= w_offmap;
      end
      if ((r_state == S_MAP) && w_hold_done) begin
        r_tex_addr <= {map_code, r_y[TILE_LOG2-1:0], r_x[TILE_LOG2-1:0]};
        r_spr_addr <= {r_y[TILE_LOG2-1:0], r_x[TILE_LOG2-1:0]};
      end
      if ((r_state == S_TEX) && w_hold_done) begin
        r_pixel <= w_pixel;
      end
    end
  end

  assign map_addr   = r_map_addr;
  assign tex_addr   = r_tex_addr;
  assign spr_addr   = r_spr_addr;
  assign xAddr      = r_x;
  assign yAddr      = r_y;
  assign pixelData  = r_pixel;
  assign pixelWrite = (r_state == S_OUT);
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tile_frame_renderer.sv
// Scoreboard bench for tile_frame_renderer on a reduced 48x40 panel with a
// 30x4 tile map (rows 4..4 off-map) and single-cycle ROM models.
module tb_tile_frame_renderer;

  localparam int SW = 48;
  localparam int SH = 40;
  localparam int NPIX = SW * SH;

  logic        clock = 1'b0;
  logic        reset, enable, blank, sprite_en;
  logic [4:0]  sprite_x;
  logic [1:0]  sprite_y;
  logic [6:0]  map_addr;
  logic [1:0]  map_code;
  logic [7:0]  tex_addr;
  logic [15:0] tex_data;
  logic [5:0]  spr_addr;
  logic [15:0] spr_data;
  logic [5:0]  xAddr, yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite, pixelReady, frame_done, busy;

  int tests_run = 0;
  int tests_failed = 0;
  int fd_count = 0;
  bit map_mode = 1'b1;

  typedef struct {int x; int y; logic [15:0] d;} pix_t;
  pix_t sb[$];

  tile_frame_renderer #(
    .SCREEN_W(SW), .SCREEN_H(SH), .TILE_LOG2(3), .MAP_W(30), .MAP_H(4),
    .TILE_BITS(2), .ROM_LAT(1), .TRANSPARENT(16'h07E0), .BLANK_COLOUR(16'h0000)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .blank(blank),
    .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .map_addr(map_addr), .map_code(map_code), .tex_addr(tex_addr), .tex_data(tex_data),
    .spr_addr(spr_addr), .spr_data(spr_data), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  // Registered ROMs: one cycle of latency from address to data.
  always @(posedge clock) begin
    map_code <= map_mode ? 2'd1 : map_addr[1:0];
    tex_data <= {tex_addr, tex_addr ^ 8'h5A};
    spr_data <= (spr_addr[2:0] == 3'd0) ? 16'h07E0 : 16'hF800;
  end

  always @(negedge clock) if (frame_done === 1'b1) fd_count++;

  function automatic logic [15:0] exp_pix(int x, int y, bit bl, bit se, int sx, int sy);
    int col, row, addr, code, px, py;
    logic [7:0] ta;
    if (bl) return 16'h0000;
    col = x / 8; row = y / 8;
    if (row >= 4 || col >= 30) return 16'h0000;
    addr = col + 30 * row;
    code = map_mode ? 1 : addr % 4;
    px = x % 8; py = y % 8;
    ta = 8'(code * 64 + py * 8 + px);
    if (se && col == sx && row == sy && px != 0) return 16'hF800;
    return {ta, ta ^ 8'h5A};
  endfunction

  task automatic push_frame(bit bl, bit se, int sx, int sy);
    pix_t p;
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++) begin
        p.x = x; p.y = y; p.d = exp_pix(x, y, bl, se, sx, sy);
        sb.push_back(p);
      end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; blank = 1'b0; sprite_en = 1'b0;
    sprite_x = '0; sprite_y = '0; pixelReady = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_xfer(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (pixelWrite === 1'b1 && pixelReady === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [39:0] got;
    do_reset();
    got = {xAddr, yAddr, pixelData, map_addr, tex_addr[4:0]};
    tests_run++;
    if (got !== '0 || tex_addr !== '0 || spr_addr !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h tex %h spr %h want 0", got, tex_addr, spr_addr);
    end
    tests_run++;
    if ({pixelWrite, frame_done, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000", {pixelWrite, frame_done, busy});
    end
  endtask

  task automatic test_latency();
    int cnt;
    do_reset();
    map_mode = 1'b1;
    enable = 1'b1;
    cnt = 0;
    while (pixelWrite !== 1'b1 && cnt < 40) begin @(negedge clock); cnt++; end
    tests_run++;
    if (cnt != 5) begin tests_failed++; $display("FAIL first_latency: got %0d want 5", cnt); end
    tests_run++;
    if (xAddr !== 6'd0 || yAddr !== 6'd0 || pixelData !== exp_pix(0, 0, 0, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL first_pixel: got (%0d,%0d)=%h want (0,0)=%h", xAddr, yAddr, pixelData, exp_pix(0, 0, 0, 0, 0, 0));
    end
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (!(pixelWrite === 1'b1 && cnt > 1) && cnt < 40);
    tests_run++;
    if (cnt != 5 || xAddr !== 6'd1) begin
      tests_failed++;
      $display("FAIL pixel_interval: got %0d x=%0d want 5 x=1", cnt, xAddr);
    end
    enable = 1'b0;
  endtask

  task automatic test_textured_frame();
    bit ok; pix_t e; int fd0;
    do_reset();
    map_mode = 1'b1;
    enable = 1'b1;
    fd0 = fd_count;
    push_frame(0, 0, 0, 0);
    for (int n = 0; n < NPIX; n++) begin
      wait_xfer(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL tex_timeout: pixel %0d got none want write", n); break; end
      e = sb.pop_front();
      if ({xAddr, yAddr, pixelData} !== {6'(e.x), 6'(e.y), e.d}) begin
        tests_failed++;
        $display("FAIL tex_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", xAddr, yAddr, pixelData, e.x, e.y, e.d);
      end
      if (n == 0) enable = 1'b0;
      if (e.x == 9 && e.y == 17) begin
        tests_run++;
        if (map_addr !== 7'd61 || tex_addr !== 8'h49) begin
          tests_failed++;
          $display("FAIL tex_addr_9_17: got map %0d tex %h want 61 49", map_addr, tex_addr);
        end
      end
    end
    @(negedge clock);
    tests_run++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_end: got done=%b busy=%b want 1 0", frame_done, busy);
    end
    @(negedge clock);
    tests_run++;
    if (frame_done !== 1'b0 || fd_count - fd0 != 1) begin
      tests_failed++;
      $display("FAIL done_pulse: got done=%b count=%0d want 0 1", frame_done, fd_count - fd0);
    end
  endtask

  task automatic test_sprite_stall();
    bit ok; pix_t e; logic [28:0] held;
    do_reset();
    map_mode = 1'b0;
    sprite_en = 1'b1; sprite_x = 5'd2; sprite_y = 2'd3;
    enable = 1'b1;
    push_frame(0, 1, 2, 3);
    for (int n = 0; n < NPIX; n++) begin
      wait_xfer(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL spr_timeout: pixel %0d got none want write", n); break; end
      if (n == 3) begin
        pixelReady = 1'b0;
        held = {pixelWrite, xAddr, yAddr, pixelData};
        for (int k = 0; k < 7; k++) begin
          @(negedge clock);
          tests_run++;
          if ({pixelWrite, xAddr, yAddr, pixelData} !== held) begin
            tests_failed++;
            $display("FAIL stall_hold: cycle %0d got %h want %h", k, {pixelWrite, xAddr, yAddr, pixelData}, held);
          end
        end
        pixelReady = 1'b1;
      end
      e = sb.pop_front();
      if ({xAddr, yAddr, pixelData} !== {6'(e.x), 6'(e.y), e.d}) begin
        tests_failed++;
        $display("FAIL spr_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", xAddr, yAddr, pixelData, e.x, e.y, e.d);
      end
      if (n == 0) enable = 1'b0;
      if (e.x == 17 && e.y == 25) begin
        tests_run++;
        if (pixelData !== 16'hF800) begin tests_failed++; $display("FAIL spr_opaque: got %h want F800", pixelData); end
      end
      if (e.x == 16 && e.y == 25) begin
        tests_run++;
        if (pixelData !== 16'h0852) begin tests_failed++; $display("FAIL spr_key: got %h want 0852", pixelData); end
      end
    end
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL spr_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back_blank();
    bit ok; pix_t e; int fd0;
    do_reset();
    map_mode = 1'b1;
    blank = 1'b1;
    enable = 1'b1;
    fd0 = fd_count;
    push_frame(1, 0, 0, 0);
    push_frame(0, 0, 0, 0);
    for (int n = 0; n < 2 * NPIX; n++) begin
      wait_xfer(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL b2b_timeout: pixel %0d got none want write", n); break; end
      e = sb.pop_front();
      if ({xAddr, yAddr, pixelData} !== {6'(e.x), 6'(e.y), e.d}) begin
        tests_failed++;
        $display("FAIL b2b_pixel: n=%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", n, xAddr, yAddr, pixelData, e.x, e.y, e.d);
      end
      if (n == 100) blank = 1'b0;
      if (n == NPIX) begin
        tests_run++;
        if (fd_count - fd0 != 1) begin tests_failed++; $display("FAIL b2b_done1: got %0d want 1", fd_count - fd0); end
      end
      if (n == NPIX + 1) enable = 1'b0;
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (fd_count - fd0 != 2 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_done2: got count=%0d busy=%b want 2 0", fd_count - fd0, busy);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok; pix_t e; bit hit;
    do_reset();
    map_mode = 1'b1;
    enable = 1'b1;
    push_frame(0, 0, 0, 0);
    hit = 1'b0;
    for (int n = 0; n < NPIX && !hit; n++) begin
      wait_xfer(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL mid_timeout: pixel %0d got none want write", n); break; end
      e = sb.pop_front();
      if ({xAddr, yAddr, pixelData} !== {6'(e.x), 6'(e.y), e.d}) begin
        tests_failed++;
        $display("FAIL mid_pixel: got (%0d,%0d)=%h want (%0d,%0d)=%h", xAddr, yAddr, pixelData, e.x, e.y, e.d);
      end
      if (e.x == 20 && e.y == 10) hit = 1'b1;
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({xAddr, yAddr, pixelData, map_addr, tex_addr, spr_addr, pixelWrite, frame_done, busy} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: got x=%0d y=%0d d=%h m=%h t=%h s=%h w=%b f=%b b=%b want all 0",
               xAddr, yAddr, pixelData, map_addr, tex_addr, spr_addr, pixelWrite, frame_done, busy);
    end
    reset = 1'b0;
    sb.delete();
    wait_xfer(ok);
    tests_run++;
    if (!ok || xAddr !== 6'd0 || yAddr !== 6'd0 || pixelData !== exp_pix(0, 0, 0, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL mid_restart: got ok=%b (%0d,%0d)=%h want (0,0)=%h", ok, xAddr, yAddr, pixelData, exp_pix(0, 0, 0, 0, 0, 0));
    end
    enable = 1'b0;
    do_reset();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; blank = 1'b0; sprite_en = 1'b0;
    sprite_x = '0; sprite_y = '0; pixelReady = 1'b1;
    test_reset();
    test_latency();
    test_textured_frame();
    test_sprite_stall();
    test_back_to_back_blank();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
